// File: rtl/csi2_pkg.sv
// CSI-2 packet constants plus the header ECC and payload CRC-16 helpers
// shared by the transmitter and its CRC engine.
package csi2_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  typedef struct packed {
    logic [7:0] wc_hi;
    logic [7:0] wc_lo;
    logic [7:0] di;
  } pkt_hdr_t;

  // Each ECC bit is the parity of a fixed subset of the 24 header bits.
  function automatic logic [7:0] csi2_ecc(input pkt_hdr_t h);
    logic [23:0] d;
    d = h;
    return {2'b00,
            ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  // Reflected CCITT polynomial; bits enter LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/csi2_crc16_2b.sv
// Two-byte-per-cycle CSI-2 payload CRC; byte [7:0] is folded in first.
module csi2_crc16_2b
  import csi2_pkg::*;
(
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)       crc <= 16'hFFFF;
    else if (init) crc <= 16'hFFFF;
    else if (en)   crc <= crc16_byte(crc16_byte(crc, data[7:0]), data[15:8]);
  end

endmodule

// File: rtl/csi2_tx_packetizer.sv
// Two-lane CSI-2 frame generator: FS, LINES long packets with CRC, FE,
// each followed by an LP gap. All outputs are registered.
//
// state     | meaning
// IDLE      | waiting for start
// FS_HDR    | frame start short packet on the lanes
// GAP       | lane_valid low for LP_GAP cycles
// LH_HDR    | long packet header on the lanes
// PAYLOAD   | payload byte pairs on the lanes
// CRC       | payload CRC on the lanes
// FE_HDR    | frame end short packet on the lanes
// DONE      | frame_done pulse
module csi2_tx_packetizer
  import csi2_pkg::*;
#(
  parameter logic [1:0]  VC            = 2'd0,
  parameter logic [5:0]  DT            = DT_RAW8,
  parameter int unsigned WORD_COUNT    = 640,
  parameter int unsigned LINES         = 480,
  parameter int unsigned LP_GAP        = 16,
  parameter logic [15:0] FRAME_NUM_RST = 16'h0001
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] lane_data,
  output logic        lane_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FS_HDR  = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_LH_HDR  = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CRC     = 3'd5;
  localparam logic [2:0] S_FE_HDR  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [15:0] WC16    = 16'(WORD_COUNT);
  localparam logic [15:0] HALF_M1 = 16'(WORD_COUNT / 2 - 1);
  localparam logic [15:0] GAP_M1  = 16'(LP_GAP - 1);
  localparam logic [15:0] LINES16 = 16'(LINES);

  logic [2:0]  state;
  logic [15:0] cnt, line_cnt, rdy_cnt, frame_num, hdr_hi, pix_q, crc, pix_word;
  logic        fe_sent, lh_enter;
  pkt_hdr_t    fs_hdr, fe_hdr, lh_hdr;

  assign fs_hdr   = {frame_num, VC, DT_FS};
  assign fe_hdr   = {frame_num, VC, DT_FE};
  assign lh_hdr   = {WC16, VC, DT};
  assign pix_word = pix_valid ? pix_data : 16'h0000;
  assign lh_enter = (state == S_GAP) && (cnt == 16'd0) && !fe_sent && (line_cnt != 16'd0);

  csi2_crc16_2b u_crc (
    .clk_50m (clk_50m),
    .rst     (rst),
    .init    (lh_enter),
    .en      (pix_ready),
    .data    (pix_word),
    .crc     (crc)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      line_cnt   <= 16'd0;
      rdy_cnt    <= 16'd0;
      frame_num  <= FRAME_NUM_RST;
      hdr_hi     <= 16'd0;
      pix_q      <= 16'd0;
      fe_sent    <= 1'b0;
      pix_ready  <= 1'b0;
      lane_data  <= 16'd0;
      lane_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Payload is fetched one cycle ahead of the lanes so the stream never stalls.
      if (lh_enter) begin
        pix_ready <= 1'b1;
        rdy_cnt   <= HALF_M1;
      end else if (pix_ready) begin
        if (rdy_cnt == 16'd0) pix_ready <= 1'b0;
        else                  rdy_cnt   <= rdy_cnt - 16'd1;
      end
      if (pix_ready) begin
        pix_q <= pix_word;
        if (!pix_valid) underrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FS_HDR;
            busy       <= 1'b1;
            underrun   <= 1'b0;
            lane_valid <= 1'b1;
            lane_data  <= {fs_hdr.wc_lo, fs_hdr.di};
            hdr_hi     <= {csi2_ecc(fs_hdr), fs_hdr.wc_hi};
            cnt        <= 16'd1;
            line_cnt   <= LINES16;
            fe_sent    <= 1'b0;
          end
        end
        S_FS_HDR, S_LH_HDR, S_FE_HDR: begin
          if (cnt != 16'd0) begin
            lane_data <= hdr_hi;
            cnt       <= 16'd0;
          end else if (state == S_LH_HDR) begin
            state     <= S_PAYLOAD;
            lane_data <= pix_q;
            cnt       <= HALF_M1;
          end else begin
            state      <= S_GAP;
            lane_valid <= 1'b0;
            lane_data  <= 16'd0;
            cnt        <= GAP_M1;
          end
        end
        S_PAYLOAD: begin
          if (cnt != 16'd0) begin
            lane_data <= pix_q;
            cnt       <= cnt - 16'd1;
          end else begin
            state     <= S_CRC;
            lane_data <= crc;
          end
        end
        S_CRC: begin
          state      <= S_GAP;
          lane_valid <= 1'b0;
          lane_data  <= 16'd0;
          cnt        <= GAP_M1;
          line_cnt   <= line_cnt - 16'd1;
        end
        S_GAP: begin
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (fe_sent) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_num  <= (frame_num == 16'hFFFF) ? 16'h0001 : frame_num + 16'd1;
          end else if (line_cnt != 16'd0) begin
            state      <= S_LH_HDR;
            lane_valid <= 1'b1;
            lane_data  <= {lh_hdr.wc_lo, lh_hdr.di};
            hdr_hi     <= {csi2_ecc(lh_hdr), lh_hdr.wc_hi};
            cnt        <= 16'd1;
          end else begin
            state      <= S_FE_HDR;
            fe_sent    <= 1'b1;
            lane_valid <= 1'b1;
            lane_data  <= {fe_hdr.wc_lo, fe_hdr.di};
            hdr_hi     <= {csi2_ecc(fe_hdr), fe_hdr.wc_hi};
            cnt        <= 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_tx_packetizer.sv
// Bench for csi2_tx_packetizer: two configurations, frame-level reference
// model of the byte stream, timing, underrun, frame number wrap and reset.
module tb_csi2_tx_packetizer;

  localparam int A_WC = 24, A_L = 2, A_G = 2;
  localparam int B_WC = 4,  B_L = 2, B_G = 3;

  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  always #10 clk_50m = ~clk_50m;

  logic        st0 = 1'b0, st1 = 1'b0, pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pd0 = 16'h0, pd1 = 16'h0;
  logic        pr0, pr1, lv0, lv1, bz0, bz1, fd0, fd1, ur0, ur1;
  logic [15:0] ld0, ld1;

  csi2_tx_packetizer #(.VC(2'd0), .WORD_COUNT(A_WC), .LINES(A_L), .LP_GAP(A_G)) u_a (
    .clk_50m(clk_50m), .rst(rst), .start(st0), .pix_data(pd0), .pix_valid(pv0),
    .pix_ready(pr0), .lane_data(ld0), .lane_valid(lv0), .busy(bz0),
    .frame_done(fd0), .underrun(ur0));

  csi2_tx_packetizer #(.VC(2'd1), .WORD_COUNT(B_WC), .LINES(B_L), .LP_GAP(B_G),
                       .FRAME_NUM_RST(16'hFFFF)) u_b (
    .clk_50m(clk_50m), .rst(rst), .start(st1), .pix_data(pd1), .pix_valid(pv1),
    .pix_ready(pr1), .lane_data(ld1), .lane_valid(lv1), .busy(bz1),
    .frame_done(fd1), .underrun(ur1));

  typedef struct packed {
    logic [15:0] ld;
    logic lv, pr, bz, fd, ur;
  } obs_t;

  typedef struct {
    int          dut;
    int          drop;
    bit          use_vec;
    logic [15:0] fnum;
    int          cycles;
    logic        ur;
    logic [15:0] fs0, fs1;
  } vec_t;

  vec_t        tbl [6];
  logic [15:0] vec_words [12];
  int n_pass = 0, n_total = 0;

  function automatic obs_t obs(input int d);
    return (d == 0) ? {ld0, lv0, pr0, bz0, fd0, ur0} : {ld1, lv1, pr1, bz1, fd1, ur1};
  endfunction

  task automatic drive(input int d, input logic st, input logic [15:0] pd, input logic pv);
    if (d == 0) begin st0 = st; pd0 = pd; pv0 = pv; end
    else        begin st1 = st; pd1 = pd; pv1 = pv; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Hamming syndrome column of each header bit.
  function automatic logic [5:0] ecc_col(input int i);
    case (i)
      0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
      4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
      8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
     12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
     16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
     20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; default: return 6'h3B;
    endcase
  endfunction

  function automatic logic [7:0] model_ecc(input logic [23:0] d);
    logic [5:0] e = 6'h0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ecc_col(i);
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] model_crc(input logic [7:0] bytes [$]);
    logic [15:0] r = 16'hFFFF;
    foreach (bytes[k])
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = r[0] ^ bytes[k][b];
        r  = {1'b0, r[15:1]};
        if (fb) r ^= 16'h8408;
      end
    return r;
  endfunction

  task automatic run_frame(input int e);
    int d, wc, nl, gap, nw, idx, cyc, nbusy, nrdy, low_run, bad;
    logic [7:0]  vc, di;
    logic [15:0] words [64];
    logic [15:0] exp_q [$];
    logic [15:0] got [$];
    logic [7:0]  bytes [$];
    int          runs [$];
    bit          done;
    obs_t        o;
    logic        fd_busy, fd_ur;
    d   = tbl[e].dut;
    wc  = (d == 0) ? A_WC : B_WC;
    nl  = (d == 0) ? A_L  : B_L;
    gap = (d == 0) ? A_G  : B_G;
    vc  = (d == 0) ? 8'h00 : 8'h40;
    nw  = nl * wc / 2;
    for (int i = 0; i < 64; i++)
      words[i] = (tbl[e].use_vec && i < 12) ? vec_words[i] : 16'($urandom);
    di = vc | 8'h00;
    exp_q.push_back({tbl[e].fnum[7:0], di});
    exp_q.push_back({model_ecc({tbl[e].fnum, di}), tbl[e].fnum[15:8]});
    for (int l = 0; l < nl; l++) begin
      di = vc | 8'h2A;
      exp_q.push_back({wc[7:0], di});
      exp_q.push_back({model_ecc({wc[15:0], di}), wc[15:8]});
      bytes.delete();
      for (int k = 0; k < wc / 2; k++) begin
        logic [15:0] w;
        w = (l * wc / 2 + k == tbl[e].drop) ? 16'h0000 : words[l * wc / 2 + k];
        exp_q.push_back(w);
        bytes.push_back(w[7:0]);
        bytes.push_back(w[15:8]);
      end
      exp_q.push_back(model_crc(bytes));
    end
    di = vc | 8'h01;
    exp_q.push_back({tbl[e].fnum[7:0], di});
    exp_q.push_back({model_ecc({tbl[e].fnum, di}), tbl[e].fnum[15:8]});

    drive(d, 1'b1, 16'h0, 1'b0);
    @(negedge clk_50m);
    idx = 0; cyc = 0; nbusy = 0; nrdy = 0; low_run = 0; done = 0;
    fd_busy = 1'b1; fd_ur = 1'b0;
    while (!done && cyc < 2000) begin
      o = obs(d);
      if (o.bz) nbusy++;
      if (o.lv) begin
        got.push_back(o.ld);
        if (low_run > 0) begin runs.push_back(low_run); low_run = 0; end
      end else if (o.bz) low_run++;
      if (o.fd) begin
        done = 1; fd_busy = o.bz; fd_ur = o.ur;
        if (low_run > 0) runs.push_back(low_run);
      end
      if (o.pr && idx < 64) begin
        nrdy++;
        drive(d, done || cyc == 6, words[idx], (idx != tbl[e].drop));
        idx++;
      end else begin
        drive(d, done || cyc == 6, 16'($urandom), 1'($urandom));
      end
      @(negedge clk_50m);
      cyc++;
    end
    o = obs(d);
    drive(d, 1'b0, 16'h0, 1'b0);
    chk($sformatf("e%0d_frame_done_seen", e), done, 1'b1);
    chk($sformatf("e%0d_start_at_done_ignored", e), {o.bz, o.lv, o.fd}, 3'b000);
    chk($sformatf("e%0d_busy_at_done", e), fd_busy, 1'b0);
    chk($sformatf("e%0d_busy_cycles", e), nbusy, tbl[e].cycles);
    chk($sformatf("e%0d_pix_ready_cycles", e), nrdy, nw);
    chk($sformatf("e%0d_underrun", e), fd_ur, tbl[e].ur);
    bad = 0;
    foreach (runs[i]) if (runs[i] != gap) bad++;
    chk($sformatf("e%0d_gap_count", e), runs.size(), nl + 2);
    chk($sformatf("e%0d_gap_len_bad", e), bad, 0);
    chk($sformatf("e%0d_stream_len", e), got.size(), exp_q.size());
    if (got.size() >= 2) begin
      chk($sformatf("e%0d_fs_pair0", e), got[0], tbl[e].fs0);
      chk($sformatf("e%0d_fs_pair1", e), got[1], tbl[e].fs1);
    end
    if (tbl[e].use_vec && got.size() > 16) chk($sformatf("e%0d_crc_vector", e), got[16], 16'h00F0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("e%0d_pair%0d", e, i), got[i], exp_q[i]);
    @(negedge clk_50m);
  endtask

  initial begin
    int n;
    vec_words = '{16'h00FF, 16'h0200, 16'hDCB9, 16'h72F3, 16'hD4BB, 16'h5AB8,
                  16'h75C8, 16'h7CC2, 16'hF881, 16'hDF05, 16'h00FF, 16'h0100};
    //        dut drop vec fnum      cyc ur  fs0       fs1
    tbl[0] = '{0, -1, 1'b1, 16'h0001, 42, 1'b0, 16'h0100, 16'h1A00};
    tbl[1] = '{0,  5, 1'b0, 16'h0002, 42, 1'b1, 16'h0200, 16'h1C00};
    tbl[2] = '{0, -1, 1'b0, 16'h0003, 42, 1'b0, 16'h0300, 16'h0600};
    tbl[3] = '{1, -1, 1'b0, 16'hFFFF, 26, 1'b0, 16'hFF40, 16'h2CFF};
    tbl[4] = '{1,  0, 1'b0, 16'h0001, 26, 1'b1, 16'h0140, 16'h0C00};
    tbl[5] = '{0, -1, 1'b0, 16'h0001, 42, 1'b0, 16'h0100, 16'h1A00};

    repeat (3) @(negedge clk_50m);
    chk("reset_held_A", obs(0), '0);
    chk("reset_held_B", obs(1), '0);
    rst = 1'b0;
    @(negedge clk_50m);
    chk("reset_released_A", obs(0), '0);
    chk("reset_released_B", obs(1), '0);

    for (int e = 0; e < 5; e++) run_frame(e);

    drive(0, 1'b1, 16'h0, 1'b0);
    @(negedge clk_50m);
    drive(0, 1'b0, 16'h0, 1'b0);
    n = 0;
    while (!pr0 && n < 60) begin @(negedge clk_50m); n++; end
    chk("rst_reach_payload", pr0, 1'b1);
    repeat (3) @(negedge clk_50m);
    chk("rst_pre_state", {lv0, bz0, ur0}, 3'b111);
    #2 rst = 1'b1;
    #1 chk("rst_async_A", obs(0), '0);
    @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    chk("rst_idle_after", obs(0), '0);
    run_frame(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csi2_tx_packetizer.md
# csi2_tx_packetizer

Two-lane MIPI CSI-2 packet transmitter producing the byte-level stream that the D-PHY receive path on the board decodes. Given a start pulse and a 16-bit pixel stream, it emits one frame of Frame Start, line long packets, and Frame End, with header ECC and payload CRC-16. It is used for loopback and self-test of the CSI-2 receive chain and sits between a pattern source and a D-PHY HS serializer.

## Interface
- VC, 0, virtual channel (2 bits) placed in DI[7:6]
- DT, 6'h2A, data type of line long packets (RAW8)
- WORD_COUNT, 640, payload bytes per line; even, 2..65534
- LINES, 480, long packets per frame; ≥1
- LP_GAP, 16, idle cycles (lane_valid low) after every packet; ≥1

- clk_50m  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins one frame when idle
- pix_data  in  16  two payload bytes; [7:0] is the earlier byte
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block consumes pix_data this cycle
- lane_data  out  16  [7:0] lane 0 byte, [15:8] lane 1 byte
- lane_valid  out  1  HS burst byte pair valid
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after final FE gap
- underrun  out  1  sticky; payload word missing during a line

## Operation
- Packet bytes b0,b1,b2… map to lanes as lane0=even, lane1=odd; one byte pair per lane_valid cycle.
- Short packet (2 cycles): {WC_lo, DI}, then {ECC, WC_hi}. FS: DT=0x00; FE: DT=0x01; WC = frame number.
- Long packet: header 2 cycles (DI={VC,DT}, WC=WORD_COUNT), WORD_COUNT/2 payload cycles, 1 CRC cycle {crc[15:8], crc[7:0]}.
- ECC: CSI-2 6-bit Hamming over {WC_hi, WC_lo, DI}, ECC[7:6]=0.
- CRC: CSI-2 CRC-16, poly x^16+x^12+x^5+1, seed 0xFFFF, LSB-first, over payload only; reseeded per line.
- FSM: IDLE → FS_HDR → GAP → (LH_HDR → PAYLOAD → CRC → GAP)×LINES → FE_HDR → GAP → DONE → IDLE.
- Frame number: 1 after reset, increments after each FE, wraps 0xFFFF→0x0001 (never 0).
- pix_ready high exactly in the WORD_COUNT/2 cycles that load payload; HS stream never stalls. pix_valid low while pix_ready high: byte pair 0x0000 sent and included in CRC, underrun set.
- underrun cleared on accepted start; start while busy ignored.

## Timing
- Reset values: lane_data=0, lane_valid=0, pix_ready=0, busy=0, frame_done=0, underrun=0; FSM IDLE, frame number 1.
- All outputs registered. start sampled high in IDLE at edge N → busy and lane_valid high from N+1 (FS first pair).
- pix_data accepted at edge K appears on lane_data after edge K+1.
- lane_valid low for exactly LP_GAP cycles between packets.
- Frame length in cycles: 4 + LINES·(3+WORD_COUNT/2) + (LINES+2)·LP_GAP, then frame_done one cycle, busy drops with it.
- start in same cycle as frame_done ignored; accepted next cycle earliest.
- rst mid-packet: immediate return to reset values; no partial packet resumes.

## Structure
- csi2_pkg: DT constants (FS 0x00, FE 0x01, RAW8 0x2A), ECC function, single-byte CRC-16 step function.
- Sub-module csi2_crc16_2b: two-byte-per-cycle CRC with init/enable, byte [7:0] processed first.

## Test plan
- FS, VC=0, frame 1 → lane pairs {0x01,0x00}, {0x1A,0x00} (ECC 0x1A).
- WORD_COUNT=24, LINES=1, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → CRC pair lane0=0xF0, lane1=0x00.
- WORD_COUNT=4, LINES=2, LP_GAP=3: frame exactly 4+2·5+4·3=26 cycles, frame_done then; pix_ready 2 cycles per line.
- pix_valid dropped for one payload cycle → 0x0000 sent, underrun=1, cleared by next start.
- Frame number preset 0xFFFF → FS/FE carry 0xFFFF, next frame carries 0x0001; start during busy ignored.
- rst asserted mid-payload → all outputs 0 asynchronously; next start restarts with FS frame 1.
